life_tracker: RTL

//   Parametrised multi-player life counter for the standoff game. Samples per-player hit

---
 rtl/life_tracker.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/life_tracker.sv
// life_tracker: per-player life counters for the standoff game.
// Each player's count lives in its own lane. The top level detects the rising edge of
// round_end, applies that round's hits through the lanes, counts round numbers and
// declares game over with either a winner or a draw.

// One player's life counter: loads MAX_LIVES on restart and decrements on a hit,
// saturating at zero. next_alive looks ahead at the value about to be registered so
// the top can decide the game result in the same cycle as the hit.
module life_lane #(
  parameter int MAX_LIVES = 3,
  parameter int LIFE_W    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              new_game,
  input  logic              dec_en,
  input  logic              hit,
  output logic [LIFE_W-1:0] lives,
  output logic              life_lost,
  output logic              next_alive
);

  logic [LIFE_W-1:0] lives_q, lives_d;
  logic              life_lost_q, life_lost_d;

  // next count: restart wins; otherwise a hit costs one life unless already at zero
  always_comb begin
    lives_d     = lives_q;
    life_lost_d = 1'b0;
    if (new_game) begin
      lives_d = LIFE_W'(MAX_LIVES);
    end else if (dec_en && hit && (lives_q != '0)) begin
      lives_d     = lives_q - LIFE_W'(1);
      life_lost_d = 1'b1;
    end
    next_alive = (lives_d != '0);
  end

  // count and loss pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lives_q     <= LIFE_W'(MAX_LIVES);
      life_lost_q <= 1'b0;
    end else begin
      lives_q     <= lives_d;
      life_lost_q <= life_lost_d;
    end
  end

  assign lives     = lives_q;
  assign life_lost = life_lost_q;

endmodule

module life_tracker #(
  parameter  int NUM_PLAYERS = 2,
  parameter  int MAX_LIVES   = 3,
  parameter  int ROUND_W     = 8,
  localparam int LIFE_W      = $clog2(MAX_LIVES + 1),
  localparam int PID_W       = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          new_game,
  input  logic                          round_end,
  input  logic [NUM_PLAYERS-1:0]        hit,
  output logic [NUM_PLAYERS*LIFE_W-1:0] lives,
  output logic [NUM_PLAYERS-1:0]        alive,
  output logic [NUM_PLAYERS-1:0]        life_lost,
  output logic [ROUND_W-1:0]            round_count,
  output logic                          game_over,
  output logic                          winner_valid,
  output logic [PID_W-1:0]              winner_id,
  output logic                          draw
);

  typedef enum logic {PLAY = 1'b0, OVER = 1'b1} state_e;

  state_e               state_q, state_d;
  logic                 round_q, round_d;
  logic [ROUND_W-1:0]   round_count_q, round_count_d;
  logic                 winner_valid_q, winner_valid_d;
  logic [PID_W-1:0]     winner_id_q, winner_id_d;
  logic                 draw_q, draw_d;

  logic                   rise;
  logic                   dec_en;
  logic [NUM_PLAYERS-1:0] next_alive;
  int                     n_surv;
  logic [PID_W-1:0]       surv_id;

  // A round only counts on the rising edge, while still playing, and not when a
  // restart arrives in the same cycle (that round is discarded).
  assign rise   = round_end & ~round_q;
  assign dec_en = rise && (state_q == PLAY) && !new_game;

  genvar g;
  generate
    for (g = 0; g < NUM_PLAYERS; g++) begin : g_lane
      life_lane #(
        .MAX_LIVES (MAX_LIVES),
        .LIFE_W    (LIFE_W)
      ) u_lane (
        .clk        (clk),
        .rst_n      (rst_n),
        .new_game   (new_game),
        .dec_en     (dec_en),
        .hit        (hit[g]),
        .lives      (lives[g*LIFE_W +: LIFE_W]),
        .life_lost  (life_lost[g]),
        .next_alive (next_alive[g])
      );
      assign alive[g] = (lives[g*LIFE_W +: LIFE_W] != '0);
    end
  endgenerate

  // survivors after this round's hits; with exactly one, surv_id is its index
  always_comb begin
    n_surv  = 0;
    surv_id = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (next_alive[i]) begin
        n_surv  = n_surv + 1;
        surv_id = PID_W'(i);
      end
    end
  end

  // game state, round counter and result flags
  always_comb begin
    state_d        = state_q;
    round_d        = round_end;
    round_count_d  = round_count_q;
    winner_valid_d = winner_valid_q;
    winner_id_d    = winner_id_q;
    draw_d         = draw_q;
    if (new_game) begin
      state_d        = PLAY;
      round_count_d  = '0;
      winner_valid_d = 1'b0;
      winner_id_d    = '0;
      draw_d         = 1'b0;
    end else if (dec_en) begin
      if (round_count_q != '1) round_count_d = round_count_q + ROUND_W'(1);
      if (n_surv == 1) begin
        state_d        = OVER;
        winner_valid_d = 1'b1;
        winner_id_d    = surv_id;
      end else if (n_surv == 0) begin
        state_d = OVER;
        draw_d  = 1'b1;
      end
    end
  end

  // control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= PLAY;
      round_q        <= 1'b0;
      round_count_q  <= '0;
      winner_valid_q <= 1'b0;
      winner_id_q    <= '0;
      draw_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      round_q        <= round_d;
      round_count_q  <= round_count_d;
      winner_valid_q <= winner_valid_d;
      winner_id_q    <= winner_id_d;
      draw_q         <= draw_d;
    end
  end

  assign game_over    = (state_q == OVER);
  assign winner_valid = winner_valid_q;
  assign winner_id    = winner_id_q;
  assign draw         = draw_q;
  assign round_count  = round_count_q;

endmodule
